// File: rtl/dram_bank_timing_ctrl_pkg.sv
// Shared types and default DRAM timing for the single-operation bank timing controller.
package dram_bank_timing_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_RD,
    CMD_WR,
    CMD_PRE
  } dram_cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_RP,
    ACT,
    WAIT_RCD,
    ACCESS,
    WAIT_WR,
    RESP
  } ctrl_state_e;

  localparam int DEF_TRCD      = 10;
  localparam int DEF_TRAS      = 22;
  localparam int DEF_TRP       = 10;
  localparam int DEF_TWR       = 7;
  localparam int DEF_BURST_LEN = 1;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dram_bank_tracker.sv
// Per-bank state: open flag, open row and a saturating cycles-since-ACT counter for tRAS.
module dram_bank_tracker #(
  parameter int ROW_ADDR_W  = 7,
  parameter int TRAS_CYCLES = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  act,
  input  logic                  pre,
  input  logic [ROW_ADDR_W-1:0] act_row,
  output logic                  is_open,
  output logic [ROW_ADDR_W-1:0] row,
  output logic                  tras_met
);

  localparam int CNT_W = $clog2(TRAS_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Counter reads N in the cycle N after the ACT, so PRE is legal once it reaches TRAS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_open <= 1'b0;
      row     <= '0;
      cnt     <= CNT_W'(TRAS_CYCLES);
    end else if (act) begin
      is_open <= 1'b1;
      row     <= act_row;
      cnt     <= CNT_W'(1);
    end else begin
      if (pre) is_open <= 1'b0;
      if (cnt < CNT_W'(TRAS_CYCLES)) cnt <= cnt + 1'b1;
    end
  end

  assign tras_met = (cnt >= CNT_W'(TRAS_CYCLES));

endmodule

// File: rtl/dram_bank_timing_ctrl.sv
// Single-operation DRAM bank timing controller: sequences PRE/ACT/RD/WR under tRCD/tRAS/tRP/tWR.
module dram_bank_timing_ctrl
  import dram_bank_timing_ctrl_pkg::*;
#(
  parameter int NUM_BANKS   = 4,
  parameter int ROW_ADDR_W  = 7,
  parameter int TRCD_CYCLES = DEF_TRCD,
  parameter int TRAS_CYCLES = DEF_TRAS,
  parameter int TRP_CYCLES  = DEF_TRP,
  parameter int TWR_CYCLES  = DEF_TWR,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  localparam int BANK_W     = clog2_min1(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [BANK_W-1:0]     req_bank,
  input  logic [ROW_ADDR_W-1:0] req_row,
  input  logic                  prech_all,
  output dram_cmd_e             dram_cmd,
  output logic [BANK_W-1:0]     dram_bank,
  output logic [ROW_ADDR_W-1:0] dram_row,
  output logic                  rsp_valid,
  output logic                  rsp_row_hit
);

  localparam int WCNT_W = clog2_min1(max3(TRCD_CYCLES, TRP_CYCLES, TWR_CYCLES));
  localparam int BCNT_W = clog2_min1(BURST_LEN);

  ctrl_state_e state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic [BCNT_W-1:0] bcnt, bcnt_nxt;

  logic [BANK_W-1:0]     bank_q;
  logic [ROW_ADDR_W-1:0] row_q;
  logic                  write_q, pall_q, hit_q;

  logic [NUM_BANKS-1:0]                 bank_open, tras_met, act_en, pre_en;
  logic [NUM_BANKS-1:0][ROW_ADDR_W-1:0] bank_row;

  logic              acc_req, acc_pall, req_hit;
  logic [BANK_W-1:0] pa_bank, pre_bank;
  logic              pa_found, pa_more, pre_ok;

  genvar gb;
  generate
    for (gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
      assign act_en[gb] = (state == ACT) && (bank_q == BANK_W'(gb));
      assign pre_en[gb] = (dram_cmd == CMD_PRE) && (dram_bank == BANK_W'(gb));
      dram_bank_tracker #(
        .ROW_ADDR_W  (ROW_ADDR_W),
        .TRAS_CYCLES (TRAS_CYCLES)
      ) u_trk (
        .clk      (clk),
        .rst_n    (rst_n),
        .act      (act_en[gb]),
        .pre      (pre_en[gb]),
        .act_row  (row_q),
        .is_open  (bank_open[gb]),
        .row      (bank_row[gb]),
        .tras_met (tras_met[gb])
      );
    end
  endgenerate

  assign req_ready = (state == IDLE) && rst_n;
  assign acc_pall  = req_ready && prech_all;
  assign acc_req   = req_ready && req_valid && !prech_all;
  assign req_hit   = bank_open[req_bank] && (bank_row[req_bank] == req_row);

  // Banks close as they are precharged, so the lowest open bank is always the next target.
  always_comb begin
    pa_bank  = '0;
    pa_found = 1'b0;
    pa_more  = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_open[b]) begin
        if (!pa_found) begin
          pa_bank  = BANK_W'(b);
          pa_found = 1'b1;
        end else begin
          pa_more = 1'b1;
        end
      end
    end
  end

  assign pre_bank = pall_q ? pa_bank : bank_q;
  assign pre_ok   = tras_met[pre_bank];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wcnt  <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    bcnt_nxt  = '0;
    case (state)
      IDLE: begin
        if (acc_pall)                  state_nxt = pa_found ? PRE : RESP;
        else if (acc_req) begin
          if (!bank_open[req_bank])    state_nxt = ACT;
          else if (req_hit)            state_nxt = ACCESS;
          else                         state_nxt = PRE;
        end
      end
      PRE: begin
        if (pre_ok) begin
          if (pall_q && pa_more)       state_nxt = PRE;
          else if (TRP_CYCLES > 1) begin
            state_nxt = WAIT_RP;
            wcnt_nxt  = WCNT_W'(TRP_CYCLES - 2);
          end else                     state_nxt = pall_q ? RESP : ACT;
        end
      end
      WAIT_RP: begin
        if (wcnt == '0)                state_nxt = pall_q ? RESP : ACT;
        else                           wcnt_nxt = wcnt - 1'b1;
      end
      ACT: begin
        if (TRCD_CYCLES > 1) begin
          state_nxt = WAIT_RCD;
          wcnt_nxt  = WCNT_W'(TRCD_CYCLES - 2);
        end else                       state_nxt = ACCESS;
      end
      WAIT_RCD: begin
        if (wcnt == '0)                state_nxt = ACCESS;
        else                           wcnt_nxt = wcnt - 1'b1;
      end
      ACCESS: begin
        if (bcnt == BCNT_W'(BURST_LEN - 1)) begin
          if (write_q && TWR_CYCLES > 1) begin
            state_nxt = WAIT_WR;
            wcnt_nxt  = WCNT_W'(TWR_CYCLES - 2);
          end else                     state_nxt = RESP;
        end else                       bcnt_nxt = bcnt + 1'b1;
      end
      WAIT_WR: begin
        if (wcnt == '0)                state_nxt = RESP;
        else                           wcnt_nxt = wcnt - 1'b1;
      end
      RESP:                            state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q  <= '0;
      row_q   <= '0;
      write_q <= 1'b0;
      pall_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else if (acc_pall || acc_req) begin
      bank_q  <= acc_pall ? '0 : req_bank;
      row_q   <= acc_pall ? '0 : req_row;
      write_q <= acc_req && req_write;
      pall_q  <= acc_pall;
      hit_q   <= acc_req && req_hit;
    end
  end

  always_comb begin
    dram_cmd    = CMD_NOP;
    dram_bank   = '0;
    dram_row    = '0;
    rsp_valid   = 1'b0;
    rsp_row_hit = 1'b0;
    case (state)
      PRE: begin
        if (pre_ok) begin
          dram_cmd  = CMD_PRE;
          dram_bank = pre_bank;
        end
      end
      ACT: begin
        dram_cmd  = CMD_ACT;
        dram_bank = bank_q;
        dram_row  = row_q;
      end
      ACCESS: begin
        dram_cmd  = write_q ? CMD_WR : CMD_RD;
        dram_bank = bank_q;
        dram_row  = row_q;
      end
      RESP: begin
        rsp_valid   = 1'b1;
        rsp_row_hit = hit_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dram_bank_timing_ctrl.sv
// Directed scoreboard bench: a timing model queues expected commands/responses, a monitor pops and checks them.
module tb_dram_bank_timing_ctrl;
  import dram_bank_timing_ctrl_pkg::*;

  localparam int NB = 4, TRCD = 10, TRAS = 22, TRP = 10, TWR = 7, BL = 1;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req_valid = 1'b0, req_write = 1'b0, prech_all = 1'b0;
  logic [1:0] req_bank = '0;
  logic [6:0] req_row = '0;
  logic       req_ready, rsp_valid, rsp_row_hit;
  dram_cmd_e  dram_cmd;
  logic [1:0] dram_bank;
  logic [6:0] dram_row;

  typedef struct packed {int cyc; dram_cmd_e cmd; logic [1:0] bank; logic [6:0] row;} cmd_t;
  typedef struct packed {int cyc; logic hit;} rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   cyc, n_cmp = 0, n_mis = 0;
  bit   m_open[NB];
  int   m_row[NB];
  int   m_act[NB];

  dram_bank_timing_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_bank(req_bank), .req_row(req_row), .prech_all(prech_all),
    .dram_cmd(dram_cmd), .dram_bank(dram_bank), .dram_row(dram_row),
    .rsp_valid(rsp_valid), .rsp_row_hit(rsp_row_hit)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the first cycle after reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge clk) begin
    cmd_t got_c, want_c;
    rsp_t got_r, want_r;
    if (rst_n) begin
      if (dram_cmd !== CMD_NOP) begin
        got_c  = '{cyc, dram_cmd, dram_bank, dram_row};
        want_c = (cmd_q.size() != 0) ? cmd_q.pop_front() : '{-1, CMD_NOP, 2'd0, 7'd0};
        n_cmp++;
        assert (got_c === want_c) else begin
          n_mis++;
          $error("FAIL cmd: got cyc=%0d %s b=%0d r=%0d, want cyc=%0d %s b=%0d r=%0d",
                 got_c.cyc, got_c.cmd.name(), got_c.bank, got_c.row,
                 want_c.cyc, want_c.cmd.name(), want_c.bank, want_c.row);
        end
      end else begin
        n_cmp++;
        assert ({dram_bank, dram_row} === 9'd0) else begin
          n_mis++;
          $error("FAIL nop_target: cyc=%0d got b=%0d r=%0d, want 0/0", cyc, dram_bank, dram_row);
        end
      end
      if (rsp_valid !== 1'b0) begin
        got_r  = '{cyc, rsp_row_hit};
        want_r = (rsp_q.size() != 0) ? rsp_q.pop_front() : '{-1, 1'b0};
        n_cmp++;
        assert (got_r === want_r) else begin
          n_mis++;
          $error("FAIL rsp: got cyc=%0d hit=%0b, want cyc=%0d hit=%0b",
                 got_r.cyc, got_r.hit, want_r.cyc, want_r.hit);
        end
      end
    end
  end

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_open[b] = 1'b0; m_row[b] = 0; m_act[b] = -1000;
    end
  endtask

  task automatic model_access(input int a, input bit w, input int b, input int r);
    int t;
    bit hit;
    hit = m_open[b] && (m_row[b] == r);
    t   = a + 1;
    if (!hit) begin
      if (m_open[b]) begin
        if (m_act[b] + TRAS > t) t = m_act[b] + TRAS;
        cmd_q.push_back('{t, CMD_PRE, 2'(b), 7'd0});
        t = t + TRP;
      end
      cmd_q.push_back('{t, CMD_ACT, 2'(b), 7'(r)});
      m_open[b] = 1'b1; m_row[b] = r; m_act[b] = t;
      t = t + TRCD;
    end
    for (int k = 0; k < BL; k++) cmd_q.push_back('{t + k, w ? CMD_WR : CMD_RD, 2'(b), 7'(r)});
    t = t + BL - 1;
    rsp_q.push_back('{w ? t + TWR : t + 1, hit});
  endtask

  task automatic model_pall(input int a);
    int t, last;
    bit any;
    t = a + 1; last = a; any = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (m_open[b]) begin
        if (m_act[b] + TRAS > t) t = m_act[b] + TRAS;
        cmd_q.push_back('{t, CMD_PRE, 2'(b), 7'd0});
        last = t; t = t + 1; m_open[b] = 1'b0; any = 1'b1;
      end
    end
    rsp_q.push_back('{any ? last + TRP : a + 1, 1'b0});
  endtask

  task automatic goto_cyc(input int a);
    while (cyc < a) @(negedge clk);
  endtask

  task automatic check_ready(input int a);
    n_cmp++;
    assert (req_ready === 1'b1 && cyc == a) else begin
      n_mis++;
      $error("FAIL ready@%0d: got ready=%b cyc=%0d, want ready=1 cyc=%0d", a, req_ready, cyc, a);
    end
  endtask

  task automatic issue(input int a, input bit w, input int b, input int r);
    goto_cyc(a);
    check_ready(a);
    req_valid = 1'b1; req_write = w; req_bank = 2'(b); req_row = 7'(r);
    model_access(a, w, b, r);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic issue_pall(input int a, input bit with_req);
    goto_cyc(a);
    check_ready(a);
    prech_all = 1'b1; req_valid = with_req; req_bank = 2'd3; req_row = 7'd77;
    model_pall(a);
    @(negedge clk);
    prech_all = 1'b0; req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((cmd_q.size() != 0 || rsp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    assert (cmd_q.size() + rsp_q.size() == 0) else begin
      n_mis++;
      $error("FAIL drain: got %0d outstanding events at cyc=%0d, want 0", cmd_q.size() + rsp_q.size(), cyc);
      cmd_q.delete();
      rsp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    assert (dram_cmd === CMD_NOP && dram_bank === 2'd0 && dram_row === 7'd0 &&
            rsp_valid === 1'b0 && rsp_row_hit === 1'b0 && req_ready === 1'b0) else begin
      n_mis++;
      $error("FAIL %s: got cmd=%0d b=%0d r=%0d rsp=%b hit=%b rdy=%b, want all 0",
             tag, dram_cmd, dram_bank, dram_row, rsp_valid, rsp_row_hit, req_ready);
    end
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_outputs("reset_state");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Closed bank, then ignored inputs while busy (cycle 5 is mid-tRCD).
    issue(0, 1'b0, 0, 5);
    goto_cyc(5);
    req_valid = 1'b1; prech_all = 1'b1; req_bank = 2'd3; req_row = 7'd1;
    @(negedge clk);
    req_valid = 1'b0; prech_all = 1'b0;
    wait_idle(200);

    issue(13, 1'b0, 0, 9);   // row miss gated by tRAS
    wait_idle(200);
    issue(50, 1'b0, 0, 9);   // read hit
    wait_idle(200);
    issue(60, 1'b1, 0, 9);   // write hit, tWR tail
    wait_idle(200);
    issue(70, 1'b0, 2, 3);   // open bank 2
    wait_idle(200);
    issue_pall(100, 1'b1);   // prech_all beats a same-cycle request
    wait_idle(200);
    issue(113, 1'b0, 0, 5);  // bank 0 closed: ACT without PRE
    wait_idle(200);
    issue(126, 1'b1, 1, 2);  // write to closed bank 1
    wait_idle(200);
    issue_pall(145, 1'b0);   // bank 1 PRE held back by tRAS
    wait_idle(200);
    issue_pall(160, 1'b0);   // nothing open
    wait_idle(200);

    // Reset during WAIT_RCD drops the operation and closes the bank.
    issue(162, 1'b0, 3, 1);
    goto_cyc(167);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_op");
    cmd_q.delete();
    rsp_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    issue(0, 1'b0, 3, 1);
    wait_idle(200);
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
